muldiv_hilo_unit: RTL and testbench
===================================

Name: muldiv_hilo_unit

Overview:
- Iterative multiply/divide engine for the execute stage. Owns the HI/LO architectural registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Exposes HI/LO to the execute-stage result mux.
- Raises a pipeline stall when a HI/LO read arrives while an operation is in flight.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  issue request, sampled on clk
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source)
- b  in  WIDTH  rt operand (divisor / multiplier)
- rd_hilo  in  1  MFHI or MFLO present in execute this cycle
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse: HI/LO just updated by a mul/div
- stall  out  1  hold pipeline
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (resetn).
- Reset values: while resetn=0, state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset asserted mid-operation aborts it; HI/LO return to 0.
- State machine: IDLE, RUN, FIX.
- IDLE:
  - start with op 100: hi<=a at the next edge; no busy, no done.
  - start with op 101: lo<=a at the next edge; no busy, no done.
  - start with op 000-011: latch |a| and |b| (signed ops) or a and b raw (unsigned ops); latch sign flags; counter<=WIDTH; go RUN.
  - Reserved op: ignored.
- RUN: one radix-2 step per cycle; counter decrements; leave for FIX on the edge where counter reaches 0.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring divide; partial remainder WIDTH+1 bits.
- FIX (one cycle): apply signs, write hi/lo at the edge leaving FIX, go IDLE.
  - Signed product negated when sa^sb.
  - Quotient negated when sa^sb; remainder takes sign of a (truncate toward zero).
- Latency: start sampled at edge E0 → hi/lo updated at edge E(WIDTH+1).
- busy: high from E0+ until E(WIDTH+1); low in the cycle hi/lo first show new values.
- done: high exactly the cycle after E(WIDTH+1).
- Products: HI = upper WIDTH bits, LO = lower WIDTH bits.
- Divides: LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = a (original operand); no exception.
- Signed overflow MIN/-1: LO = MIN, HI = 0.
- start while busy: ignored entirely, including MTHI/MTLO. Upstream must hold the instruction via stall.
- stall = busy & (rd_hilo | start), combinational. Deasserts the cycle hi/lo are valid, so MFHI/MFLO read the new value.
- hi/lo change only at the FIX exit edge or an MTHI/MTLO edge; never partially during RUN.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: ops 000/001 bypass RUN. IDLE → FIX directly, FIX computes the product with a full-width multiplier, hi/lo written at E1, done high the cycle after E1, busy high one cycle only. Divides unchanged.
- Undefined: multiplies iterate WIDTH cycles as above; no hardware multiplier inferred.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1 at E33; done pulses 1 cycle; busy high 33 cycles.
- MULTU a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE. DIVU a=100, b=7 → lo=14, hi=2.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234. MTHI a=0xA5A5A5A5 in IDLE → hi updates next edge, busy stays 0, done stays 0.
- During a DIV: assert rd_hilo → stall=1 until the hi/lo-valid cycle. Issue MTLO mid-operation → ignored; lo holds the divide result.
- Drop resetn at cycle 10 of a MULT → hi=lo=0 and busy=0 immediately. A new MULT after release completes normally.

Source files
------------

// File: rtl/muldiv_hilo_unit_if.sv
// Issue/result bundle between the execute stage and muldiv_hilo_unit.
interface muldiv_hilo_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rd_hilo;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, rd_hilo, input busy, done, stall, hi, lo);
  modport slave  (input start, op, a, b, rd_hilo, output busy, done, stall, hi, lo);
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO, plus MTHI/MTLO and a HI/LO read stall.
// Define MULDIV_FAST_MUL_EN to compute multiplies in a single FIX cycle with a full multiplier.
module muldiv_hilo_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic              clk,
  input  logic              resetn,
  muldiv_hilo_unit_if.slave bus
);
  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [W2-1:0]    acc_q;
  logic [WIDTH-1:0] opb_q;
  logic             sa_q, sb_q, div_q, bz_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q;

  logic             issue_c, arith_c, mthi_c, mtlo_c, step_c, commit_c, fast_c;
  logic             na_c, nb_c;
  logic [WIDTH-1:0] amag_c, bmag_c;
  logic [WIDTH:0]   msum_c, shifted_c, diff_c;
  logic             ge_c;
  logic [W2-1:0]    step_acc_c, prod_c, sprod_c;
  logic [WIDTH-1:0] q_c, r_c, hi_fix_c, lo_fix_c;

  assign issue_c = (state_q == S_IDLE) && bus.start;

`ifdef MULDIV_FAST_MUL_EN
  assign fast_c = (bus.op[2:1] == 2'b00);
  assign prod_c = W2'(acc_q[WIDTH-1:0]) * W2'(opb_q);
`else
  assign fast_c = 1'b0;
  assign prod_c = acc_q;
`endif

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (arith_c) state_d = fast_c ? S_FIX : S_RUN;
      S_RUN:   if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control decode; starts outside IDLE are dropped here
  always_comb begin
    arith_c  = 1'b0;
    mthi_c   = 1'b0;
    mtlo_c   = 1'b0;
    step_c   = 1'b0;
    commit_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        arith_c = issue_c && !bus.op[2];
        mthi_c  = issue_c && (bus.op == 3'b100);
        mtlo_c  = issue_c && (bus.op == 3'b101);
      end
      S_RUN:   step_c   = 1'b1;
      S_FIX:   commit_c = 1'b1;
      default: ;
    endcase
  end

  // Operand magnitudes for signed ops (op[0]=0)
  assign na_c   = !bus.op[0] && bus.a[WIDTH-1];
  assign nb_c   = !bus.op[0] && bus.b[WIDTH-1];
  assign amag_c = na_c ? -bus.a : bus.a;
  assign bmag_c = nb_c ? -bus.b : bus.b;

  // One radix-2 step: shift-add multiply or restoring divide
  always_comb begin
    msum_c    = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : (WIDTH+1)'(0));
    shifted_c = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    diff_c    = shifted_c - {1'b0, opb_q};
    ge_c      = (shifted_c >= {1'b0, opb_q});
    if (div_q)
      step_acc_c = {(ge_c ? diff_c[WIDTH-1:0] : shifted_c[WIDTH-1:0]), acc_q[WIDTH-2:0], ge_c};
    else
      step_acc_c = {msum_c, acc_q[WIDTH-1:1]};
  end

  // Sign fix-up; a zero divisor leaves |a| as remainder, so HI comes back as a
  always_comb begin
    sprod_c  = (sa_q ^ sb_q) ? -prod_c : prod_c;
    q_c      = bz_q ? {WIDTH{1'b1}}
                    : ((sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    r_c      = sa_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
    hi_fix_c = div_q ? r_c : sprod_c[W2-1:WIDTH];
    lo_fix_c = div_q ? q_c : sprod_c[WIDTH-1:0];
  end

  // Iteration datapath
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q <= '0;
      opb_q <= '0;
      cnt_q <= '0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      div_q <= 1'b0;
      bz_q  <= 1'b0;
    end else if (arith_c) begin
      acc_q <= {WIDTH'(0), (bus.op[1] ? amag_c : bmag_c)};
      opb_q <= bus.op[1] ? bmag_c : amag_c;
      cnt_q <= CNT_W'(WIDTH);
      sa_q  <= na_c;
      sb_q  <= nb_c;
      div_q <= bus.op[1];
      bz_q  <= (bus.b == '0);
    end else if (step_c) begin
      acc_q <= step_acc_c;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Architectural HI/LO and status
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d != S_IDLE);
      done_q <= commit_c;
      if (commit_c) begin
        hi_q <= hi_fix_c;
        lo_q <= lo_fix_c;
      end else begin
        if (mthi_c) hi_q <= bus.a;
        if (mtlo_c) lo_q <= bus.a;
      end
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.stall = busy_q & (bus.rd_hilo | bus.start);

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed bench for muldiv_hilo_unit: expected HI/LO queued at issue, compared on done.
module tb_muldiv_hilo_unit;
  localparam int unsigned W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic clk;
  logic resetn;
  int   errors;
  int   checks;
  logic [63:0] sb[$];
  logic [31:0] exp_hi, exp_lo;

  muldiv_hilo_unit_if #(.WIDTH(W)) bus ();
  muldiv_hilo_unit #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference result {hi, lo}
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax, bx;
    int signed   sa, sbv, q, r;
    model = '0;
    case (op)
      3'b000: begin
        ax = {{32{a[31]}}, a};
        bx = {{32{b[31]}}, b};
        model = ax * bx;
      end
      3'b001: model = {32'd0, a} * {32'd0, b};
      3'b010: begin
        if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'd0, 32'h8000_0000};
        else begin
          sa = a; sbv = b;
          q = sa / sbv;
          r = sa % sbv;
          model = {32'(r), 32'(q)};
        end
      end
      3'b011: begin
        if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
        else model = {a % b, a / b};
      end
      default: model = '0;
    endcase
  endfunction

  task automatic drive_start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits for done, then pops and compares; stall_mode also checks stall and injects an MTLO
  task automatic wait_result(input string tag, input int exp_lat, input bit stall_mode);
    int lat = 0;
    int busy_cyc = 0;
    bit seen = 1'b0;
    logic [63:0] e;
    for (int k = 0; k < 200; k++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busy_cyc++;
      if (stall_mode) begin
        chk({tag, "_stall_hi"}, 64'(bus.stall), 64'd1);
        if (k == 5) begin
          bus.start = 1'b1;
          bus.op    = 3'b101;
          bus.a     = 32'hDEAD_BEEF;
        end else begin
          bus.start = 1'b0;
        end
      end
      lat++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    e = (sb.size() > 0) ? sb.pop_front() : 64'hX;
    chk({tag, "_hi"}, 64'(bus.hi), 64'(e[63:32]));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(e[31:0]));
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(exp_lat));
    chk({tag, "_busy_low"}, 64'(bus.busy), 64'd0);
    if (stall_mode) chk({tag, "_stall_low"}, 64'(bus.stall), 64'd0);
    exp_hi = e[63:32];
    exp_lo = e[31:0];
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    sb.push_back(model(op, a, b));
    drive_start(op, a, b);
    wait_result(tag, op[1] ? DIV_LAT : MUL_LAT, 1'b0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    errors = 0;
    checks = 0;
    exp_hi = '0;
    exp_lo = '0;
    bus.start   = 1'b0;
    bus.op      = 3'b000;
    bus.a       = '0;
    bus.b       = '0;
    bus.rd_hilo = 1'b0;
    resetn      = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    resetn = 1'b1;

    run_op(3'b000, 32'hFFFF_FFFD, 32'd5, "mult_neg");
    run_op(3'b001, 32'hFFFF_FFFF, 32'd2, "multu");
    run_op(3'b011, 32'd100, 32'd7, "divu");
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, "div_neg");
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'b011, 32'h0000_1234, 32'd0, "divu_zero");
    run_op(3'b010, 32'hFFFF_FFF0, 32'd0, "div_zero_neg");
    run_op(3'b000, 32'h8000_0000, 32'h8000_0000, "mult_min");

    for (int i = 0; i < 6; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : $urandom;
      run_op(rop, ra, rb, "rand");
    end

    // MTHI / MTLO in IDLE
    drive_start(3'b100, 32'hA5A5_A5A5, 32'd0);
    chk("mthi_hi", 64'(bus.hi), 64'h0000_0000_A5A5_A5A5);
    chk("mthi_lo", 64'(bus.lo), 64'(exp_lo));
    chk("mthi_busy", 64'(bus.busy), 64'd0);
    chk("mthi_done", 64'(bus.done), 64'd0);
    exp_hi = 32'hA5A5_A5A5;
    drive_start(3'b101, 32'h5A5A_5A5A, 32'd0);
    chk("mtlo_lo", 64'(bus.lo), 64'h0000_0000_5A5A_5A5A);
    chk("mtlo_hi", 64'(bus.hi), 64'(exp_hi));
    chk("mtlo_busy", 64'(bus.busy), 64'd0);
    exp_lo = 32'h5A5A_5A5A;

    // Reserved op is ignored
    drive_start(3'b110, 32'h1111_2222, 32'h3333_4444);
    chk("rsv_busy", 64'(bus.busy), 64'd0);
    chk("rsv_hi", 64'(bus.hi), 64'(exp_hi));
    chk("rsv_lo", 64'(bus.lo), 64'(exp_lo));
    @(negedge clk);
    chk("rsv_done", 64'(bus.done), 64'd0);

    // HI/LO read during a divide stalls; an MTLO issued mid-operation is dropped
    sb.push_back(model(3'b010, 32'hFFFF_FF9C, 32'd7));
    drive_start(3'b010, 32'hFFFF_FF9C, 32'd7);
    bus.rd_hilo = 1'b1;
    wait_result("div_stall", DIV_LAT, 1'b1);
    bus.rd_hilo = 1'b0;

    // Reset in the middle of a MULT
    sb.push_back(model(3'b000, 32'h1234_5678, 32'h9ABC_DEF0));
    drive_start(3'b000, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("midrst_hi", 64'(bus.hi), 64'd0);
    chk("midrst_lo", 64'(bus.lo), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    void'(sb.pop_front());
    exp_hi = '0;
    exp_lo = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    run_op(3'b000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, "mult_after_rst");

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
